// File: rtl/mul_sched.sv
// mul_sched: shares one multiplier datapath between two requesters.
//
// Requests are arbitrated round-robin in IDLE. The winner's operands are
// registered onto mul_a/mul_b and the multiplier clear is pulsed for one
// cycle (CLEAR). The block then waits LATENCY cycles (WAIT), captures mul_z
// into resp_z and pulses resp_valid with the requester ID.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid/a/b           requester N operation and operands (N = 0, 1)
//   reqN_ready               requester N accepted this cycle (combinational)
//   mul_a, mul_b             registered operands to the multiplier
//   mul_clr                  registered clear to the multiplier
//   mul_z                    multiplier product
//   resp_valid/id/z          one-cycle response with captured product
//   busy                     high whenever the FSM is not in IDLE
module mul_sched #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_clr,
  input  logic [2*WIDTH-1:0] mul_z,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_z,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       op_id;
  logic       grant0;
  logic       grant1;
  logic       accept;

  // Round-robin grant; only offered while idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        // On a tie the requester that did not win last time goes first.
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Next-state logic for the IDLE -> CLEAR -> WAIT sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_CLEAR;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, operand, counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_clr    <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_z     <= '0;
      busy       <= 1'b0;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
    end else begin
      state      <= state_next;
      // Clear and busy are registered copies of the upcoming state so the
      // outputs carry no combinational path from the requesters.
      mul_clr    <= (state_next == S_CLEAR);
      busy       <= (state_next != S_IDLE);
      resp_valid <= 1'b0;

      if (accept) begin
        mul_a      <= grant1 ? req1_a : req0_a;
        mul_b      <= grant1 ? req1_b : req0_b;
        op_id      <= grant1;
        last_grant <= grant1;
      end

      if (state == S_CLEAR) begin
        cnt <= LAT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          resp_z     <= mul_z;
          resp_valid <= 1'b1;
          resp_id    <= op_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed bench for mul_sched with a stub multiplier.
// Instance u_dut uses LATENCY=2, instance u_dut1 uses LATENCY=1.
module tb_mul_sched;

  logic clk;
  logic rst;

  // LATENCY=2 instance signals
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic        mul_clr, resp_valid, resp_id, busy;
  logic [63:0] mul_z, resp_z;

  // LATENCY=1 instance signals
  logic        l1_req0_valid, l1_req1_valid, l1_req0_ready, l1_req1_ready;
  logic [31:0] l1_req0_a, l1_req0_b, l1_req1_a, l1_req1_b, l1_mul_a, l1_mul_b;
  logic        l1_mul_clr, l1_resp_valid, l1_resp_id, l1_busy;
  logic [63:0] l1_mul_z, l1_resp_z;

  logic [4:0] cyc0, cyc1;

  int vectors;
  int miscompares;

  mul_sched #(.WIDTH(32), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_clr(mul_clr), .mul_z(mul_z),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z), .busy(busy)
  );

  mul_sched #(.WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(l1_req0_valid), .req0_a(l1_req0_a), .req0_b(l1_req0_b), .req0_ready(l1_req0_ready),
    .req1_valid(l1_req1_valid), .req1_a(l1_req1_a), .req1_b(l1_req1_b), .req1_ready(l1_req1_ready),
    .mul_a(l1_mul_a), .mul_b(l1_mul_b), .mul_clr(l1_mul_clr), .mul_z(l1_mul_z),
    .resp_valid(l1_resp_valid), .resp_id(l1_resp_id), .resp_z(l1_resp_z), .busy(l1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multipliers: count cycles since clear release; product valid from
  // the LATENCY-th cycle after release, otherwise a junk pattern.
  always @(posedge clk) begin
    if (mul_clr) cyc0 <= 5'd0;
    else if (cyc0 != 5'd31) cyc0 <= cyc0 + 5'd1;
    if (l1_mul_clr) cyc1 <= 5'd0;
    else if (cyc1 != 5'd31) cyc1 <= cyc1 + 5'd1;
  end

  assign mul_z    = (!mul_clr && (int'(cyc0) + 1 >= 2)) ? (64'(mul_a) * 64'(mul_b))
                                                        : 64'hBAD0_BAD0_BAD0_BAD0;
  assign l1_mul_z = (!l1_mul_clr && (int'(cyc1) + 1 >= 1)) ? (64'(l1_mul_a) * 64'(l1_mul_b))
                                                           : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle after acceptance; returns cycles from acceptance.
  task automatic wait_resp0(input int budget, output int n);
    n = 1;
    while (!resp_valid && n < budget) begin
      step();
      n++;
    end
    check_val("resp_seen", 64'(resp_valid), 64'd1);
  endtask

  int n;
  int r;
  int last;
  logic bad;
  logic [63:0] exp_z [4];
  logic        exp_id [4];

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    l1_req0_valid = 1'b0; l1_req1_valid = 1'b0;
    l1_req0_a = 32'd0; l1_req0_b = 32'd0; l1_req1_a = 32'd0; l1_req1_b = 32'd0;
    exp_z[0] = 64'd6; exp_z[1] = 64'd63; exp_z[2] = 64'd6; exp_z[3] = 64'd63;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;

    // Reset values
    #3;
    check_val("rst_mul_a", 64'(mul_a), 64'd0);
    check_val("rst_mul_b", 64'(mul_b), 64'd0);
    check_val("rst_mul_clr", 64'(mul_clr), 64'd1);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_resp_id", 64'(resp_id), 64'd0);
    check_val("rst_resp_z", resp_z, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    step();
    check_val("rst_clr_held", 64'(mul_clr), 64'd1);
    rst = 1'b0;
    step();
    check_val("clr_drop", 64'(mul_clr), 64'd0);

    // Single op 3*5 from req0
    req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h5;
    #1;
    check_val("t1_ready0", 64'(req0_ready), 64'd1);
    check_val("t1_ready1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    check_val("t1_clr", 64'(mul_clr), 64'd1);
    check_val("t1_mul_a", 64'(mul_a), 64'd3);
    check_val("t1_mul_b", 64'(mul_b), 64'd5);
    check_val("t1_busy1", 64'(busy), 64'd1);
    step();
    check_val("t1_clr_off", 64'(mul_clr), 64'd0);
    check_val("t1_busy2", 64'(busy), 64'd1);
    step();
    check_val("t1_busy3", 64'(busy), 64'd1);
    check_val("t1_no_resp", 64'(resp_valid), 64'd0);
    step();
    check_val("t1_resp_valid", 64'(resp_valid), 64'd1);
    check_val("t1_resp_id", 64'(resp_id), 64'd0);
    check_val("t1_resp_z", resp_z, 64'h0000_0000_0000_000F);
    check_val("t1_busy_low", 64'(busy), 64'd0);
    step();
    check_val("t1_pulse_end", 64'(resp_valid), 64'd0);

    // Tie then alternation, starting from a fresh reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd9;
    #1;
    check_val("t2_tie_r0", 64'(req0_ready), 64'd1);
    check_val("t2_tie_r1", 64'(req1_ready), 64'd0);
    r = 0; last = 0;
    for (int c = 1; c <= 40 && r < 4; c++) begin
      step();
      if (resp_valid) begin
        check_val("t2_id", 64'(resp_id), 64'(exp_id[r]));
        check_val("t2_z", resp_z, exp_z[r]);
        if (r > 0) check_val("t2_spacing", 64'(c - last), 64'd4);
        if (exp_id[r]) check_val("t2_b2b_r0", 64'(req0_ready), 64'd1);
        else           check_val("t2_b2b_r1", 64'(req1_ready), 64'd1);
        last = c;
        r++;
        if (r == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    check_val("t2_count", 64'(r), 64'd4);
    step();
    check_val("t2_idle", 64'(busy), 64'd0);

    // Full-width operands from req1 alone
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
    #1;
    check_val("t3_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    n = 1; bad = 1'b0;
    while (!resp_valid && n < 10) begin
      if (req0_ready) bad = 1'b1;
      step();
      n++;
    end
    if (req0_ready) bad = 1'b1;
    check_val("t3_seen", 64'(resp_valid), 64'd1);
    check_val("t3_r0_quiet", 64'(bad), 64'd0);
    check_val("t3_id", 64'(resp_id), 64'd1);
    check_val("t3_z", resp_z, 64'hFFFF_FFFE_0000_0001);

    // Hold while busy: req0 waits for req1's response cycle
    step();
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd7;
    #1;
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd11;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (req0_ready) bad = 1'b1;
      step();
    end
    check_val("t4_hold", 64'(bad), 64'd0);
    check_val("t4_resp_valid", 64'(resp_valid), 64'd1);
    check_val("t4_resp_id", 64'(resp_id), 64'd1);
    check_val("t4_resp_z", resp_z, 64'd42);
    check_val("t4_accept", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check_val("t4_mul_a", 64'(mul_a), 64'd10);
    wait_resp0(10, n);
    check_val("t4_lat", 64'(n), 64'd4);
    check_val("t4_z2", resp_z, 64'd110);
    check_val("t4_id2", 64'(resp_id), 64'd0);

    // Reset in the middle of WAIT
    step();
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
    #1;
    step();
    req1_valid = 1'b0;
    step();
    check_val("t5_in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_val("t5_clr", 64'(mul_clr), 64'd1);
    check_val("t5_busy", 64'(busy), 64'd0);
    check_val("t5_mul_a", 64'(mul_a), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (resp_valid) bad = 1'b1;
    end
    check_val("t5_no_resp", 64'(bad), 64'd0);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1;
    #1;
    check_val("t5_tie_r0", 64'(req0_ready), 64'd1);
    check_val("t5_tie_r1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp0(10, n);
    check_val("t5_lat", 64'(n), 64'd4);
    check_val("t5_id", 64'(resp_id), 64'd0);
    check_val("t5_z", resp_z, 64'h10);

    // LATENCY=1 instance
    l1_req0_valid = 1'b1; l1_req0_a = 32'hCCCC_CCCC; l1_req0_b = 32'h2;
    #1;
    check_val("t6_ready", 64'(l1_req0_ready), 64'd1);
    step();
    l1_req0_valid = 1'b0;
    n = 1;
    while (!l1_resp_valid && n < 10) begin
      step();
      n++;
    end
    check_val("t6_seen", 64'(l1_resp_valid), 64'd1);
    check_val("t6_lat", 64'(n), 64'd3);
    check_val("t6_z", l1_resp_z, 64'h0000_0001_9999_9998);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
